// File: rtl/esm_dep_scheduler.sv
// ---------------------------------------------------------------------------
// esm_dep_scheduler
//   Instruction-dependency scheduler for the ESM core. Holds up to BS in-flight
//   instructions. Each slot keeps a dependency row of length BS, and a
//   register-producer table records the slot that will write each register.
//   Decode allocates slots and execute/commit completes them. A completion
//   releases its dependency column and frees the slot. A registered issue
//   stage hands one dependency-free slot downstream per cycle.
//
//   Ports
//     clk, rst                 clock (rising edge), async active-high reset
//     alloc_valid/alloc_ready  allocate handshake; alloc_tag = slot to be used
//     alloc_rs1/rs2/rd(+_en)   source/destination registers of the new entry
//     issue_valid/issue_ready  registered issue handshake; issue_tag = slot
//     cmpl_valid, cmpl_tag     completion of an issued slot
//     cmpl_err                 1-cycle pulse after a completion of a slot that
//                              is not valid and issued
//     occupancy, full, empty   fill status
//
//   Build option: ESM_AGE_PRIO_EN adds an age matrix so issue picks the
//   oldest ready slot. Without it, issue picks the lowest-index ready slot.
// ---------------------------------------------------------------------------
module esm_dep_scheduler #(
    parameter int REGNUM = 32,
    parameter int BS     = 16,
    parameter int RA     = $clog2(REGNUM),
    parameter int BB     = $clog2(BS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alloc_valid,
    output logic          alloc_ready,
    input  logic [RA-1:0] alloc_rs1,
    input  logic          alloc_rs1_en,
    input  logic [RA-1:0] alloc_rs2,
    input  logic          alloc_rs2_en,
    input  logic [RA-1:0] alloc_rd,
    input  logic          alloc_rd_en,
    output logic [BB-1:0] alloc_tag,
    output logic          issue_valid,
    input  logic          issue_ready,
    output logic [BB-1:0] issue_tag,
    input  logic          cmpl_valid,
    input  logic [BB-1:0] cmpl_tag,
    output logic          cmpl_err,
    output logic [BB:0]   occupancy,
    output logic          full,
    output logic          empty
);

    logic [BS-1:0]             valid_q, valid_d;
    logic [BS-1:0]             issued_q, issued_d;
    logic [BS-1:0][BS-1:0]     dep_q, dep_d;        // dep_q[i][j]: slot i waits on slot j
    logic [REGNUM-1:0]         prod_valid_q, prod_valid_d;
    logic [REGNUM-1:0][BB-1:0] prod_tag_q, prod_tag_d;
    logic                      issue_valid_q, issue_valid_d;
    logic [BB-1:0]             issue_tag_q, issue_tag_d;
    logic                      cmpl_err_q, cmpl_err_d;
    logic [BB:0]               occupancy_q, occupancy_d;

    logic [BB-1:0] free_idx;
    logic [BB-1:0] sel_idx;
    logic          sel_any;
    logic [BS-1:0] cand;
    logic [BS-1:0] new_dep;
    logic          alloc_fire, cmpl_fire, issue_load;

`ifdef ESM_AGE_PRIO_EN
    logic [BS-1:0][BS-1:0] age_q, age_d;            // age_q[i][j]: slot i allocated before slot j
    logic [BS-1:0]         has_older;
`endif

    // Lowest-index free slot; the free set is the pre-edge one, so a slot
    // completing this cycle is not reused until the next cycle.
    always_comb begin
        free_idx = '0;
        for (int i = BS-1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = BB'(i);
        end
    end

    assign alloc_fire = alloc_valid & ~(&valid_q);
    assign cmpl_fire  = cmpl_valid & valid_q[cmpl_tag] & issued_q[cmpl_tag];
    assign issue_load = ~issue_valid_q | issue_ready;

    // The slot currently in the issue register already has issued=1, so it is
    // never offered again.
    always_comb begin
        for (int i = 0; i < BS; i++) begin
            cand[i] = valid_q[i] & ~issued_q[i] & ~(|dep_q[i]);
        end
    end

    always_comb begin
        sel_idx = '0;
        sel_any = |cand;
`ifdef ESM_AGE_PRIO_EN
        // Exactly one candidate has no older candidate ahead of it.
        for (int i = 0; i < BS; i++) begin
            has_older[i] = 1'b0;
            for (int j = 0; j < BS; j++) begin
                has_older[i] = has_older[i] | (cand[j] & age_q[j][i]);
            end
        end
        for (int i = BS-1; i >= 0; i--) begin
            if (cand[i] && !has_older[i]) sel_idx = BB'(i);
        end
`else
        for (int i = BS-1; i >= 0; i--) begin
            if (cand[i]) sel_idx = BB'(i);
        end
`endif
    end

    // Sources look up the table before this allocation's own rd update. A
    // producer completing this cycle is already satisfied.
    always_comb begin
        new_dep = '0;
        if (alloc_rs1_en && alloc_rs1 != '0 && prod_valid_q[alloc_rs1]
            && !(cmpl_fire && prod_tag_q[alloc_rs1] == cmpl_tag))
            new_dep[prod_tag_q[alloc_rs1]] = 1'b1;
        if (alloc_rs2_en && alloc_rs2 != '0 && prod_valid_q[alloc_rs2]
            && !(cmpl_fire && prod_tag_q[alloc_rs2] == cmpl_tag))
            new_dep[prod_tag_q[alloc_rs2]] = 1'b1;
    end

    always_comb begin
        valid_d       = valid_q;
        issued_d      = issued_q;
        dep_d         = dep_q;
        prod_valid_d  = prod_valid_q;
        prod_tag_d    = prod_tag_q;
        issue_valid_d = issue_valid_q;
        issue_tag_d   = issue_tag_q;
        cmpl_err_d    = cmpl_valid & ~cmpl_fire;
        occupancy_d   = occupancy_q + (BB+1)'(alloc_fire) - (BB+1)'(cmpl_fire);
`ifdef ESM_AGE_PRIO_EN
        age_d         = age_q;
`endif

        if (cmpl_fire) begin
            valid_d[cmpl_tag]  = 1'b0;
            issued_d[cmpl_tag] = 1'b0;
            for (int i = 0; i < BS; i++) dep_d[i][cmpl_tag] = 1'b0;
            // Only the current producer is cleared; after a WAW overwrite the
            // tag no longer matches and the newer producer survives.
            for (int r = 0; r < REGNUM; r++) begin
                if (prod_tag_q[r] == cmpl_tag) prod_valid_d[r] = 1'b0;
            end
`ifdef ESM_AGE_PRIO_EN
            age_d[cmpl_tag] = '0;
            for (int i = 0; i < BS; i++) age_d[i][cmpl_tag] = 1'b0;
`endif
        end

        // Applied after the completion clears so a same-register allocation wins.
        if (alloc_fire) begin
            valid_d[free_idx]  = 1'b1;
            issued_d[free_idx] = 1'b0;
            dep_d[free_idx]    = new_dep;
            if (alloc_rd_en && alloc_rd != '0) begin
                prod_valid_d[alloc_rd] = 1'b1;
                prod_tag_d[alloc_rd]   = free_idx;
            end
`ifdef ESM_AGE_PRIO_EN
            age_d[free_idx] = '0;
            for (int i = 0; i < BS; i++) begin
                age_d[i][free_idx] = valid_q[i] & ~(cmpl_fire & (cmpl_tag == BB'(i)));
            end
`endif
        end

        if (issue_load) begin
            issue_valid_d = sel_any;
            if (sel_any) begin
                issue_tag_d       = sel_idx;
                issued_d[sel_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q       <= '0;
            issued_q      <= '0;
            dep_q         <= '0;
            prod_valid_q  <= '0;
            prod_tag_q    <= '0;
            issue_valid_q <= 1'b0;
            issue_tag_q   <= '0;
            cmpl_err_q    <= 1'b0;
            occupancy_q   <= '0;
`ifdef ESM_AGE_PRIO_EN
            age_q         <= '0;
`endif
        end else begin
            valid_q       <= valid_d;
            issued_q      <= issued_d;
            dep_q         <= dep_d;
            prod_valid_q  <= prod_valid_d;
            prod_tag_q    <= prod_tag_d;
            issue_valid_q <= issue_valid_d;
            issue_tag_q   <= issue_tag_d;
            cmpl_err_q    <= cmpl_err_d;
            occupancy_q   <= occupancy_d;
`ifdef ESM_AGE_PRIO_EN
            age_q         <= age_d;
`endif
        end
    end

    assign alloc_ready = ~(&valid_q);
    assign alloc_tag   = free_idx;
    assign full        = &valid_q;
    assign empty       = ~(|valid_q);
    assign issue_valid = issue_valid_q;
    assign issue_tag   = issue_tag_q;
    assign cmpl_err    = cmpl_err_q;
    assign occupancy   = occupancy_q;

endmodule

// File: tb/tb_esm_dep_scheduler.sv
// Testbench for esm_dep_scheduler: directed scenarios plus randomized traffic
// against an instruction-level reference model (sequence numbers, last-writer
// map per register, in-flight set).
module tb_esm_dep_scheduler;
    localparam int REGNUM = 32;
    localparam int BS     = 16;
    localparam int RA     = 5;
    localparam int BB     = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          alloc_valid, alloc_ready;
    logic [RA-1:0] alloc_rs1, alloc_rs2, alloc_rd;
    logic          alloc_rs1_en, alloc_rs2_en, alloc_rd_en;
    logic [BB-1:0] alloc_tag;
    logic          issue_valid, issue_ready;
    logic [BB-1:0] issue_tag;
    logic          cmpl_valid;
    logic [BB-1:0] cmpl_tag;
    logic          cmpl_err;
    logic [BB:0]   occupancy;
    logic          full, empty;

    int total = 0;
    int bad   = 0;

    esm_dep_scheduler #(.REGNUM(REGNUM), .BS(BS)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_rs1(alloc_rs1), .alloc_rs1_en(alloc_rs1_en),
        .alloc_rs2(alloc_rs2), .alloc_rs2_en(alloc_rs2_en),
        .alloc_rd(alloc_rd), .alloc_rd_en(alloc_rd_en),
        .alloc_tag(alloc_tag),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_tag(issue_tag),
        .cmpl_valid(cmpl_valid), .cmpl_tag(cmpl_tag), .cmpl_err(cmpl_err),
        .occupancy(occupancy), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // Reference model: each allocation gets a sequence number; a dependency is
    // the sequence number of the last writer, satisfied once that instruction
    // is no longer in flight.
    bit m_valid[BS];
    bit m_issued[BS];
    int m_seq[BS];
    int m_dep1[BS];
    int m_dep2[BS];
    int m_last[REGNUM];
    bit m_iv;
    int m_it;
    bit m_err;
    int next_seq;

    function automatic bit alive(input int s);
        if (s < 0) return 1'b0;
        for (int i = 0; i < BS; i++) if (m_valid[i] && m_seq[i] == s) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < BS; i++) begin
            m_valid[i] = 0; m_issued[i] = 0; m_seq[i] = -1; m_dep1[i] = -1; m_dep2[i] = -1;
        end
        for (int r = 0; r < REGNUM; r++) m_last[r] = -1;
        m_iv = 0; m_it = 0; m_err = 0; next_seq = 0;
    endtask

    task automatic model_step();
        int  at = -1;
        int  sel = -1;
        int  d1 = -1;
        int  d2 = -1;
        int  ct;
        int  cseq;
        bit  afire, cfire, load;
        ct = int'(cmpl_tag);
        for (int i = 0; i < BS; i++) if (!m_valid[i] && at < 0) at = i;
        afire = alloc_valid && at >= 0;
        cfire = cmpl_valid && m_valid[ct] && m_issued[ct];
        cseq  = m_seq[ct];
        load  = !m_iv || issue_ready;
        if (load) begin
            for (int i = 0; i < BS; i++) begin
                if (m_valid[i] && !m_issued[i] && !alive(m_dep1[i]) && !alive(m_dep2[i])) begin
`ifdef ESM_AGE_PRIO_EN
                    if (sel < 0 || m_seq[i] < m_seq[sel]) sel = i;
`else
                    if (sel < 0) sel = i;
`endif
                end
            end
        end
        if (afire) begin
            if (alloc_rs1_en && alloc_rs1 != 0 && alive(m_last[alloc_rs1])
                && !(cfire && m_last[alloc_rs1] == cseq)) d1 = m_last[alloc_rs1];
            if (alloc_rs2_en && alloc_rs2 != 0 && alive(m_last[alloc_rs2])
                && !(cfire && m_last[alloc_rs2] == cseq)) d2 = m_last[alloc_rs2];
        end
        if (load) begin
            m_iv = (sel >= 0);
            if (sel >= 0) begin m_it = sel; m_issued[sel] = 1; end
        end
        if (cfire) m_valid[ct] = 0;
        if (afire) begin
            m_valid[at] = 1; m_issued[at] = 0; m_seq[at] = next_seq;
            m_dep1[at] = d1; m_dep2[at] = d2;
            if (alloc_rd_en && alloc_rd != 0) m_last[alloc_rd] = next_seq;
            next_seq++;
        end
        m_err = cmpl_valid && !cfire;
    endtask

    task automatic drive(input bit av, input int r1, input bit e1, input int r2, input bit e2,
                         input int rd, input bit ed, input bit ir, input bit cv, input int ct);
        alloc_valid = av;
        alloc_rs1 = RA'(r1); alloc_rs1_en = e1;
        alloc_rs2 = RA'(r2); alloc_rs2_en = e2;
        alloc_rd  = RA'(rd); alloc_rd_en  = ed;
        issue_ready = ir;
        cmpl_valid = cv; cmpl_tag = BB'(ct);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        alloc_valid = 0; alloc_rs1 = '0; alloc_rs1_en = 0; alloc_rs2 = '0; alloc_rs2_en = 0;
        alloc_rd = '0; alloc_rd_en = 0; issue_ready = 0; cmpl_valid = 0; cmpl_tag = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL rst_issue_valid got=%0b exp=0", issue_valid); end
        total++; if (occupancy !== 5'd0) begin bad++; $display("FAIL rst_occupancy got=%0d exp=0", occupancy); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%0b exp=1", empty); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL rst_full got=%0b exp=0", full); end
        total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL rst_alloc_ready got=%0b exp=1", alloc_ready); end
        total++; if (alloc_tag !== 4'd0) begin bad++; $display("FAIL rst_alloc_tag got=%0d exp=0", alloc_tag); end
        total++; if (cmpl_err !== 1'b0) begin bad++; $display("FAIL rst_cmpl_err got=%0b exp=0", cmpl_err); end
        // Asynchronous reset in the middle of operation
        drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #2;
        total++; if (occupancy !== 5'd0) begin bad++; $display("FAIL async_rst_occupancy got=%0d exp=0", occupancy); end
        total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL async_rst_issue_valid got=%0b exp=0", issue_valid); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL async_rst_empty got=%0b exp=1", empty); end
    endtask

    task automatic test_dep_chain();
        apply_reset();
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);   // tag0: rd=x5
        drive(1, 5, 1, 0, 0, 6, 1, 0, 0, 0);   // tag1: rs1=x5, rd=x6
        total++; if (issue_valid !== 1'b1 || issue_tag !== 4'd0) begin bad++; $display("FAIL chain_issue0 got=%0b/%0d exp=1/0", issue_valid, issue_tag); end
        total++; if (alloc_tag !== 4'd2 || occupancy !== 5'd2) begin bad++; $display("FAIL chain_alloc got=%0d/%0d exp=2/2", alloc_tag, occupancy); end
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL chain_blocked got=%0b exp=0", issue_valid); end
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);   // complete tag0
        total++; if (issue_valid !== 1'b0 || occupancy !== 5'd1) begin bad++; $display("FAIL chain_cmpl got=%0b/%0d exp=0/1", issue_valid, occupancy); end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        total++; if (issue_valid !== 1'b1 || issue_tag !== 4'd1) begin bad++; $display("FAIL chain_issue1 got=%0b/%0d exp=1/1", issue_valid, issue_tag); end
    endtask

    task automatic test_fill();
        apply_reset();
        for (int k = 0; k < BS; k++) drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        total++; if (full !== 1'b1 || alloc_ready !== 1'b0 || occupancy !== 5'd16) begin
            bad++; $display("FAIL fill_full got=%0b/%0b/%0d exp=1/0/16", full, alloc_ready, occupancy); end
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);   // blocked allocation
        total++; if (occupancy !== 5'd16 || full !== 1'b1) begin bad++; $display("FAIL fill_blocked got=%0d/%0b exp=16/1", occupancy, full); end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 5);   // complete tag5
        total++; if (alloc_tag !== 4'd5 || alloc_ready !== 1'b1 || occupancy !== 5'd15 || full !== 1'b0) begin
            bad++; $display("FAIL fill_free got=%0d/%0b/%0d/%0b exp=5/1/15/0", alloc_tag, alloc_ready, occupancy, full); end
    endtask

    task automatic test_hold();
        apply_reset();
        for (int k = 0; k < 4; k++) drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        total++; if (issue_valid !== 1'b1 || issue_tag !== 4'd3) begin bad++; $display("FAIL hold_start got=%0b/%0d exp=1/3", issue_valid, issue_tag); end
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            total++; if (issue_valid !== 1'b1 || issue_tag !== 4'd3) begin bad++; $display("FAIL hold_stable cyc=%0d got=%0b/%0d exp=1/3", k, issue_valid, issue_tag); end
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        total++; if (issue_valid !== 1'b1 || issue_tag !== 4'd4) begin bad++; $display("FAIL hold_next got=%0b/%0d exp=1/4", issue_valid, issue_tag); end
    endtask

    task automatic test_same_cycle();
        apply_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);   // tag2 writes x7
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        drive(1, 7, 1, 0, 0, 0, 0, 1, 1, 2);   // complete tag2 + allocate reader of x7
        total++; if (alloc_tag !== 4'd2 || occupancy !== 5'd3) begin bad++; $display("FAIL same_slot got=%0d/%0d exp=2/3", alloc_tag, occupancy); end
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        total++; if (issue_valid !== 1'b1 || issue_tag !== 4'd3) begin bad++; $display("FAIL same_issue got=%0b/%0d exp=1/3", issue_valid, issue_tag); end
    endtask

    task automatic test_waw_err();
        apply_reset();
        drive(1, 0, 0, 0, 0, 4, 1, 1, 0, 0);   // tag0 rd=x4
        drive(1, 0, 0, 0, 0, 4, 1, 1, 0, 0);   // tag1 rd=x4
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);   // complete tag0
        drive(1, 4, 1, 0, 0, 0, 0, 1, 0, 0);   // reader of x4 -> slot0, waits on tag1
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);   // complete unissued slot0
        total++; if (cmpl_err !== 1'b1) begin bad++; $display("FAIL waw_err_pulse got=%0b exp=1", cmpl_err); end
        total++; if (issue_valid !== 1'b0 || occupancy !== 5'd2) begin bad++; $display("FAIL waw_waiting got=%0b/%0d exp=0/2", issue_valid, occupancy); end
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);   // complete tag1
        total++; if (cmpl_err !== 1'b0) begin bad++; $display("FAIL waw_err_clear got=%0b exp=0", cmpl_err); end
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        total++; if (issue_valid !== 1'b1 || issue_tag !== 4'd0) begin bad++; $display("FAIL waw_issue got=%0b/%0d exp=1/0", issue_valid, issue_tag); end
    endtask

    task automatic test_age_order();
        int exp_tag[4];
`ifdef ESM_AGE_PRIO_EN
        exp_tag = '{1, 2, 3, 0};
`else
        exp_tag = '{0, 1, 2, 3};
`endif
        apply_reset();
        for (int k = 0; k < 4; k++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);   // free slot0 while held in issue register
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);   // reallocate slot0
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
            total++; if (issue_valid !== 1'b1 || issue_tag !== BB'(exp_tag[k])) begin
                bad++; $display("FAIL age_order idx=%0d got=%0b/%0d exp=1/%0d", k, issue_valid, issue_tag, exp_tag[k]); end
        end
    endtask

    task automatic test_random();
        int iss_list[$];
        int ct, cnt, lo;
        bit cv;
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            iss_list.delete();
            for (int i = 0; i < BS; i++) if (m_valid[i] && m_issued[i]) iss_list.push_back(i);
            cv = ($urandom_range(0, 9) < 4);
            ct = int'($urandom_range(0, BS-1));
            if (iss_list.size() > 0 && $urandom_range(0, 9) < 9)
                ct = iss_list[$urandom_range(0, iss_list.size()-1)];
            drive($urandom_range(0, 9) < 6,
                  int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 9) < 7, cv, ct);
            cnt = 0; lo = -1;
            for (int i = 0; i < BS; i++) begin
                if (m_valid[i]) cnt++;
                else if (lo < 0) lo = i;
            end
            total++; if (issue_valid !== m_iv) begin bad++; $display("FAIL rnd_issue_valid cyc=%0d got=%0b exp=%0b", c, issue_valid, m_iv); end
            if (m_iv) begin
                total++; if (issue_tag !== BB'(m_it)) begin bad++; $display("FAIL rnd_issue_tag cyc=%0d got=%0d exp=%0d", c, issue_tag, m_it); end
            end
            total++; if (occupancy !== (BB+1)'(cnt)) begin bad++; $display("FAIL rnd_occupancy cyc=%0d got=%0d exp=%0d", c, occupancy, cnt); end
            total++; if (full !== (cnt == BS) || empty !== (cnt == 0) || alloc_ready !== (cnt != BS)) begin
                bad++; $display("FAIL rnd_flags cyc=%0d got=%0b/%0b/%0b cnt=%0d", c, full, empty, alloc_ready, cnt); end
            if (lo >= 0) begin
                total++; if (alloc_tag !== BB'(lo)) begin bad++; $display("FAIL rnd_alloc_tag cyc=%0d got=%0d exp=%0d", c, alloc_tag, lo); end
            end
            total++; if (cmpl_err !== m_err) begin bad++; $display("FAIL rnd_cmpl_err cyc=%0d got=%0b exp=%0b", c, cmpl_err, m_err); end
        end
    endtask

    initial begin
        test_reset();
        test_dep_chain();
        test_fill();
        test_hold();
        test_same_cycle();
        test_waw_err();
        test_age_order();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
